// File: rtl/nrzi_rx_deser_if.sv
// nrzi_rx_deser_if: word-side valid/ready port with the sticky overrun flag and its clear
interface nrzi_rx_deser_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data_out;
  logic data_valid;
  logic data_ready;
  logic overrun;
  logic overrun_clr;
  modport master(output data_out, data_valid, overrun, input data_ready, overrun_clr);
  modport slave(input data_out, data_valid, overrun, output data_ready, overrun_clr);
endinterface

// File: rtl/nrzi_rx_deser.sv
// nrzi_rx_deser: NRZI line decoder and LSB-first deserialiser onto a valid/ready word port
module nrzi_rx_deser #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  input  logic bit_en,
  input  logic frame_start,
  nrzi_rx_deser_if.master bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);
  logic prev_line, dbit, done, accept;
  logic [CNT_W-1:0] bit_cnt, cnt_base, cnt_nx;
  logic [WIDTH-1:0] shift, shift_nx, word;
  always_comb begin
    dbit = line_in ^ prev_line;
    cnt_base = frame_start ? '0 : bit_cnt;
    done = bit_en && cnt_base == CNT_W'(WIDTH - 1);
    cnt_nx = done ? '0 : cnt_base + 1'b1;
    shift_nx = shift;
    shift_nx[cnt_base[IW-1:0]] = dbit;
    word = {dbit, shift[WIDTH-2:0]};
    accept = !bus.data_valid || bus.data_ready;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_line <= 1'b0;
      bit_cnt <= '0;
      shift <= '0;
      bus.data_out <= '0;
      bus.data_valid <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (bit_en) begin
        prev_line <= line_in;
        shift <= shift_nx;
        bit_cnt <= cnt_nx;
      end else if (frame_start) begin
        bit_cnt <= '0;
      end
      if (done && accept) begin
        bus.data_out <= word;
        bus.data_valid <= 1'b1;
      end else if (bus.data_valid && bus.data_ready) begin
        bus.data_valid <= 1'b0;
      end
      bus.overrun <= (done && !accept) || (bus.overrun && !bus.overrun_clr);
    end
  end
endmodule

// File: tb/tb_nrzi_rx_deser.sv
// tb_nrzi_rx_deser: directed NRZI words with a scoreboard queue checked by a handshake monitor
module tb_nrzi_rx_deser;
  logic clk = 0, reset = 1, line_in = 0, bit_en = 0, frame_start = 0;
  logic m_prev = 0;
  int passed = 0, total = 0;
  logic [7:0] exp_q[$];
  nrzi_rx_deser_if #(.WIDTH(8)) bus ();
  nrzi_rx_deser #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .line_in(line_in), .bit_en(bit_en),
    .frame_start(frame_start), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk)
    if (!reset && bus.data_valid && bus.data_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL word: got %0h with no expected word queued at %0t", bus.data_out, $time);
      end else check("word", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
    end
  task automatic idle(input int n, input bit tog);
    repeat (n) begin
      @(posedge clk); #1;
      bit_en = 0;
      frame_start = 0;
      if (tog) line_in = ~line_in;
    end
  endtask
  task automatic send(input logic [7:0] w, input int n, input bit gaps, input bit rdy_last, input bit fs_first);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle($urandom_range(0, 3), 1);
      @(posedge clk); #1;
      line_in = m_prev ^ w[i];
      m_prev = line_in;
      bit_en = 1;
      frame_start = fs_first && i == 0;
      if (rdy_last && i == n - 1) bus.data_ready = 1;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.data_ready = 0;
    bus.overrun_clr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check("reset valid", {31'd0, bus.data_valid}, 0);
    check("reset data", {24'd0, bus.data_out}, 0);
    check("reset overrun", {31'd0, bus.overrun}, 0);
    exp_q.push_back(8'h9A);
    send(8'h9A, 8, 0, 0, 0);
    check("latency pre", {31'd0, bus.data_valid}, 0);
    idle(1, 0);
    check("latency valid", {31'd0, bus.data_valid}, 1);
    check("first word", {24'd0, bus.data_out}, 32'h9A);
    send(8'h55, 8, 0, 0, 0);
    idle(1, 0);
    check("overrun set", {31'd0, bus.overrun}, 1);
    check("stall data", {24'd0, bus.data_out}, 32'h9A);
    check("stall valid", {31'd0, bus.data_valid}, 1);
    @(posedge clk); #1 bus.overrun_clr = 1;
    @(posedge clk); #1 bus.overrun_clr = 0;
    check("overrun clr", {31'd0, bus.overrun}, 0);
    exp_q.push_back(8'hC3);
    send(8'hC3, 8, 0, 1, 0);
    @(posedge clk); #1;
    bit_en = 0;
    bus.data_ready = 0;
    check("b2b valid", {31'd0, bus.data_valid}, 1);
    check("b2b data", {24'd0, bus.data_out}, 32'hC3);
    check("b2b overrun", {31'd0, bus.overrun}, 0);
    @(posedge clk); #1 bus.data_ready = 1;
    @(posedge clk); #1;
    check("drain valid", {31'd0, bus.data_valid}, 0);
    send(8'h0D, 5, 0, 0, 0);
    @(posedge clk); #1;
    bit_en = 0;
    frame_start = 1;
    exp_q.push_back(8'h3C);
    send(8'h3C, 8, 0, 0, 0);
    idle(2, 0);
    check("realign data", {24'd0, bus.data_out}, 32'h3C);
    send(8'h07, 3, 0, 0, 0);
    exp_q.push_back(8'h5B);
    send(8'h5B, 8, 0, 0, 1);
    idle(2, 0);
    bus.data_ready = 0;
    send(8'hA5, 8, 0, 0, 0);
    idle(1, 0);
    check("pre-reset data", {24'd0, bus.data_out}, 32'hA5);
    send(8'h0F, 4, 0, 0, 0);
    @(posedge clk); #1;
    bit_en = 0;
    reset = 1;
    @(posedge clk); #1 reset = 0;
    check("mid reset valid", {31'd0, bus.data_valid}, 0);
    check("mid reset data", {24'd0, bus.data_out}, 0);
    check("mid reset overrun", {31'd0, bus.overrun}, 0);
    m_prev = 0;
    bus.data_ready = 1;
    exp_q.push_back(8'hE7);
    send(8'hE7, 8, 0, 0, 0);
    idle(2, 0);
    exp_q.push_back(8'h9A);
    send(8'h9A, 8, 1, 0, 0);
    idle(2, 0);
    check("gap data", {24'd0, bus.data_out}, 32'h9A);
    check("queue empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
